pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Generic inter-stage pipeline register: successor to per-stage hand-instanced RegWithWE banks.
//  Carries a DATA_W payload, a CTRL_W control vector and an EXC_W exception cause.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so it runs at full throughput with a registered o_ready.
//  Supports flush, zeroes control bits on bubbles, and applies an overflow exception-cause override at capture.
//  Used between IF/ID/EXE/MEM/WB.
// PARAMETERS
//  DATA_W    64     payload width (pc, instr, operands, results packed by the instantiating stage)
//  CTRL_W    8      control/write-enable bits; forced to 0 on o_ctrl whenever o_valid=0
//  EXC_W     5      exception cause width
//  OV_CAUSE  5'h0c  cause code substituted when i_ovf=1 at capture
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  i_valid      in   1       upstream beat valid
//  o_ready      out  1       stage can accept; registered (= skid entry empty)
//  i_data       in   DATA_W  upstream payload
//  i_ctrl       in   CTRL_W  upstream control bits
//  i_exc_cause  in   EXC_W   upstream exception cause
//  i_ovf        in   1       ALU overflow; overrides cause with OV_CAUSE
//  i_flush      in   1       discard all held and incoming beats
//  o_valid      out  1       downstream beat valid
//  i_ready      in   1       downstream accepts
//  o_data       out  DATA_W  held payload
//  o_ctrl       out  CTRL_W  held control, masked by o_valid
//  o_exc_cause  out  EXC_W   held cause
//  o_occupancy  out  2       entries held (0..2)
// BEHAVIOUR
//  - Storage: main entry (drives outputs) and skid entry. Each entry holds {valid,data,ctrl,cause}.
//  - Accept = i_valid & o_ready. Consume = o_valid & i_ready. Captured cause = i_ovf ? OV_CAUSE : i_exc_cause.
//  - FSM on {main_v,skid_v}:
//    - EMPTY: accept -> ONE (load main).
//    - ONE: accept & consume -> ONE (load main); accept & !consume -> TWO (load skid);
//      !accept & consume -> EMPTY; otherwise hold.
//    - TWO: o_ready=0; consume -> ONE (main<=skid); otherwise hold.
//    - {0,1} is illegal and unreachable.
//  - Latency: 1 cycle from accept to o_valid in EMPTY, or in ONE with consume. Sustains 1 beat/cycle.
//  - o_ready registered: o_ready = ~skid_v, and 0 while reset=1.
//  - Backpressure: outputs stable while o_valid=1 & i_ready=0. No beat is ever dropped or duplicated.
//  - i_flush=1: next cycle main_v=skid_v=0 and o_occupancy=0. Flush wins over a simultaneous accept/consume;
//    the accepted beat is discarded. o_data/o_exc_cause hold stale values; o_ctrl reads 0. o_ready=1 the next cycle.
//  - Bubble: o_valid=0 forces o_ctrl=0, so write enables never fire on bubbles.
//  - Reset (sync): o_valid=0, o_occupancy=0, o_data=0, o_ctrl=0, o_exc_cause=0, o_ready=0 during reset.
//    o_ready=1 the first cycle after release. Reset mid-transfer drops all held beats.
//  - Overflow override applies to whichever entry captures the beat (main or skid); the cause travels with the data.
// TESTING
//  1. Reset 3 cycles, release -> o_valid=0, o_ctrl=0, o_data=0, o_ready=1 in cycle 1 after release.
//  2. i_ready=1, 10 back-to-back beats data=0..9 -> o_valid every cycle from cycle 1, order 0..9, o_occupancy<=1.
//  3. Send A,B,C with i_ready=0 -> A,B accepted, o_ready=0, occupancy=2, C held off.
//     Release i_ready -> A,B,C delivered in order.
//  4. Beat cause=5'h04, i_ovf=1 -> o_exc_cause=5'h0c. Next beat i_ovf=0, cause=5'h04 -> 5'h04. Repeat into skid entry.
//  5. Occupancy=2, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, occupancy=0, o_ready=1;
//     the flushed beat never appears at the output.
//  6. Random i_valid/i_ready/i_flush, 10k cycles vs scoreboard -> no loss/duplication, ctrl=0 on every bubble.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg
// Description : Inter-stage pipeline register with a valid/ready handshake and
//               a 2-entry skid buffer. Full throughput with a registered
//               o_ready. Supports flush, masks control bits on bubbles and
//               substitutes an overflow exception cause at capture time.
// Ports       :
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready registered)
//   i_data, i_ctrl,     upstream payload, control bits, exception cause
//   i_exc_cause, i_ovf  (i_ovf replaces the cause with OV_CAUSE)
//   i_flush             discard all held and incoming beats
//   o_valid / i_ready   downstream handshake
//   o_data, o_ctrl,     held beat; o_ctrl reads 0 whenever o_valid=0
//   o_exc_cause
//   o_occupancy         number of held entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 8,
  parameter int                EXC_W    = 5,
  parameter logic [EXC_W-1:0]  OV_CAUSE = 5'h0c
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [EXC_W-1:0]  i_exc_cause,
  input  logic              i_ovf,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [EXC_W-1:0]  o_exc_cause,
  output logic [1:0]        o_occupancy
);

  // State encodes {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t            state;
  logic              ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [EXC_W-1:0]  main_cause, skid_cause;

  logic              main_v;
  logic              accept;
  logic              consume;
  logic [EXC_W-1:0]  cap_cause;

  assign main_v    = (state == ONE) || (state == TWO);
  assign accept    = i_valid & ready_q;
  assign consume   = main_v & i_ready;
  assign cap_cause = i_ovf ? OV_CAUSE : i_exc_cause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      ready_q    <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      main_cause <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_cause <= '0;
    end else if (i_flush) begin
      // Payload registers keep stale contents; only the valid bits drop.
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            main_data  <= i_data;
            main_ctrl  <= i_ctrl;
            main_cause <= cap_cause;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data  <= i_data;
            main_ctrl  <= i_ctrl;
            main_cause <= cap_cause;
            ready_q    <= 1'b1;
          end else if (accept) begin
            // Downstream stalled: park the new beat in the skid entry and
            // stop accepting until it drains.
            skid_data  <= i_data;
            skid_ctrl  <= i_ctrl;
            skid_cause <= cap_cause;
            ready_q    <= 1'b0;
            state      <= TWO;
          end else if (consume) begin
            ready_q <= 1'b1;
            state   <= EMPTY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        TWO: begin
          if (consume) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            main_cause <= skid_cause;
            ready_q    <= 1'b1;
            state      <= ONE;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = main_v;
  assign o_data      = main_data;
  assign o_ctrl      = main_ctrl & {CTRL_W{main_v}};
  assign o_exc_cause = main_cause;
  assign o_occupancy = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid_reg
// Description : Directed and random self-checking bench for
//               pipe_stage_skid_reg. Inputs change and outputs are observed
//               on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int EXC_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic [EXC_W-1:0]  i_exc_cause;
  logic              i_ovf;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [EXC_W-1:0]  o_exc_cause;
  logic [1:0]        o_occupancy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [EXC_W-1:0]  e;
  } beat_t;

  pipe_stage_skid_reg #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .EXC_W   (EXC_W),
    .OV_CAUSE(5'h0c)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_ctrl     (i_ctrl),
    .i_exc_cause(i_exc_cause),
    .i_ovf      (i_ovf),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_ctrl     (o_ctrl),
    .o_exc_cause(o_exc_cause),
    .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic [EXC_W-1:0] e,
                       input logic ovf);
    i_valid = v; i_data = d; i_ctrl = c; i_exc_cause = e; i_ovf = ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b want 0", o_ready); end
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", o_ready); end
    vectors++;
    if (o_valid !== 1'b0 || o_ctrl !== '0 || o_data !== '0 || o_exc_cause !== '0 || o_occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got v=%b ctrl=%h data=%h exc=%h occ=%0d want all 0",
               o_valid, o_ctrl, o_data, o_exc_cause, o_occupancy);
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 10) begin
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 64'(k - 1) || o_ctrl !== 8'(k)) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: got v=%b data=%h ctrl=%h want v=1 data=%h ctrl=%h",
                   k - 1, o_valid, o_data, o_ctrl, 64'(k - 1), 8'(k));
        end
        vectors++;
        if (o_occupancy > 2'd1 || o_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_occ%0d: got occ=%0d ready=%b want occ<=1 ready=1", k - 1, o_occupancy, o_ready);
        end
      end
      if (k == 11) begin
        vectors++;
        if (o_valid !== 1'b0 || o_ctrl !== '0) begin
          miscompares++;
          $display("FAIL b2b_drained: got v=%b ctrl=%h want v=0 ctrl=0", o_valid, o_ctrl);
        end
      end
      if (k < 10) drive(1'b1, 64'(k), 8'(k + 1), '0, 1'b0);
      else        drive(1'b0, '0, '0, '0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    drive(1'b1, 64'hA, 8'h0a, '0, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 64'hA || o_occupancy !== 2'd1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_A_held: got v=%b data=%h occ=%0d ready=%b want 1 a 1 1", o_valid, o_data, o_occupancy, o_ready);
    end
    drive(1'b1, 64'hB, 8'h0b, '0, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_occupancy !== 2'd2 || o_ready !== 1'b0 || o_data !== 64'hA) begin
      miscompares++;
      $display("FAIL bp_full: got occ=%0d ready=%b data=%h want 2 0 a", o_occupancy, o_ready, o_data);
    end
    drive(1'b1, 64'hC, 8'h0c, '0, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_occupancy !== 2'd2 || o_ready !== 1'b0 || o_data !== 64'hA || o_ctrl !== 8'h0a) begin
      miscompares++;
      $display("FAIL bp_C_held_off: got occ=%0d ready=%b data=%h ctrl=%h want 2 0 a 0a",
               o_occupancy, o_ready, o_data, o_ctrl);
    end
    i_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 64'hB || o_occupancy !== 2'd1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_B_out: got v=%b data=%h occ=%0d ready=%b want 1 b 1 1", o_valid, o_data, o_occupancy, o_ready);
    end
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 64'hC || o_ctrl !== 8'h0c) begin
      miscompares++;
      $display("FAIL bp_C_out: got v=%b data=%h ctrl=%h want 1 c 0c", o_valid, o_data, o_ctrl);
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_ctrl !== '0) begin
      miscompares++;
      $display("FAIL bp_drained: got v=%b occ=%0d ctrl=%h want 0 0 0", o_valid, o_occupancy, o_ctrl);
    end
  endtask

  task automatic test_overflow();
    i_ready = 1'b1;
    drive(1'b1, 64'h100, 8'h01, 5'h04, 1'b1);
    @(negedge clk);
    vectors++;
    if (o_exc_cause !== 5'h0c || o_data !== 64'h100) begin
      miscompares++;
      $display("FAIL ovf_main: got exc=%h data=%h want 0c 100", o_exc_cause, o_data);
    end
    drive(1'b1, 64'h101, 8'h01, 5'h04, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_exc_cause !== 5'h04 || o_data !== 64'h101) begin
      miscompares++;
      $display("FAIL no_ovf_main: got exc=%h data=%h want 04 101", o_exc_cause, o_data);
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    i_ready = 1'b0;
    drive(1'b1, 64'h200, 8'h02, 5'h04, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'h201, 8'h02, 5'h04, 1'b1);
    @(negedge clk);
    vectors++;
    if (o_occupancy !== 2'd2 || o_exc_cause !== 5'h04 || o_data !== 64'h200) begin
      miscompares++;
      $display("FAIL ovf_skid_main: got occ=%0d exc=%h data=%h want 2 04 200", o_occupancy, o_exc_cause, o_data);
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    i_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_exc_cause !== 5'h0c || o_data !== 64'h201 || o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_skid: got exc=%h data=%h v=%b want 0c 201 1", o_exc_cause, o_data, o_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    drive(1'b1, 64'hA0, 8'h11, 5'h01, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'hB0, 8'h22, 5'h02, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_occupancy !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_setup: got occ=%0d want 2", o_occupancy);
    end
    drive(1'b1, 64'hF0, 8'h33, 5'h03, 1'b0);
    i_flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_ctrl !== '0 || o_occupancy !== 2'd0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full: got v=%b ctrl=%h occ=%0d ready=%b want 0 0 0 1", o_valid, o_ctrl, o_occupancy, o_ready);
    end
    vectors++;
    if (o_data !== 64'hA0) begin
      miscompares++;
      $display("FAIL flush_stale_data: got %h want a0", o_data);
    end
    // Flush coinciding with an accept into a one-entry stage.
    i_flush = 1'b0;
    drive(1'b1, 64'hC0, 8'h44, 5'h04, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'hD0, 8'h55, 5'h05, 1'b0);
    i_flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_ctrl !== '0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_accept: got v=%b occ=%0d ctrl=%h ready=%b want 0 0 0 1", o_valid, o_occupancy, o_ctrl, o_ready);
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_data !== 64'hC0) begin
      miscompares++;
      $display("FAIL flush_no_ghost: got v=%b data=%h want 0 c0", o_valid, o_data);
    end
  endtask

  task automatic test_mid_reset();
    i_ready = 1'b0;
    drive(1'b1, 64'h55, 8'h66, 5'h07, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'h56, 8'h67, 5'h07, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_ready !== 1'b0 || o_data !== '0 || o_exc_cause !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b occ=%0d ready=%b data=%h exc=%h want 0 0 0 0 0",
               o_valid, o_occupancy, o_ready, o_data, o_exc_cause);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: got ready=%b v=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic  acc, con;
    int    occ;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      occ = q.size();
      vectors++;
      if (o_occupancy !== 2'(occ) || o_valid !== (occ != 0) || o_ready !== (occ != 2)) begin
        miscompares++;
        $display("FAIL rand_state cyc%0d: got occ=%0d v=%b ready=%b want occ=%0d", cyc, o_occupancy, o_valid, o_ready, occ);
      end
      vectors++;
      if (occ == 0) begin
        if (o_ctrl !== '0) begin
          miscompares++;
          $display("FAIL rand_bubble_ctrl cyc%0d: got %h want 0", cyc, o_ctrl);
        end
      end else if (o_data !== q[0].d || o_ctrl !== q[0].c || o_exc_cause !== q[0].e) begin
        miscompares++;
        $display("FAIL rand_beat cyc%0d: got data=%h ctrl=%h exc=%h want %h %h %h",
                 cyc, o_data, o_ctrl, o_exc_cause, q[0].d, q[0].c, q[0].e);
      end
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom),
            5'($urandom), 1'($urandom_range(0, 3) == 0));
      i_ready = 1'($urandom_range(0, 2) != 0);
      i_flush = 1'($urandom_range(0, 31) == 0);
      acc = i_valid && (occ != 2);
      con = (occ != 0) && i_ready;
      if (i_flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) begin
          b.d = i_data;
          b.c = i_ctrl;
          b.e = i_ovf ? 5'h0c : i_exc_cause;
          q.push_back(b);
        end
      end
    end
    @(negedge clk);
    i_flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_flush();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
